// File: rtl/noc_axilite_pkg.sv
// rtl/noc_axilite_pkg.sv - shared encodings for the NoC memory-ack to AXI-Lite response scheduler
// NoC field macros default here when define.tmp.h has not already provided them.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_TYPE
`define MSG_TYPE 29:22
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 37:30
`endif
`ifndef MSG_TYPE_NC_LOAD_MEM_ACK
`define MSG_TYPE_NC_LOAD_MEM_ACK 8'd26
`endif
`ifndef MSG_TYPE_NC_STORE_MEM_ACK
`define MSG_TYPE_NC_STORE_MEM_ACK 8'd27
`endif

package noc_axilite_pkg;
    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2,
        ST_RESP = 2'd3
    } sched_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic TAG_LOAD  = 1'b0;
    localparam logic TAG_STORE = 1'b1;

    localparam logic [7:0] NC_LOAD_MEM_ACK  = `MSG_TYPE_NC_LOAD_MEM_ACK;
    localparam logic [7:0] NC_STORE_MEM_ACK = `MSG_TYPE_NC_STORE_MEM_ACK;
endpackage

// File: rtl/noc_axilite_tag_fifo.sv
// rtl/noc_axilite_tag_fifo.sv - in-order 1-bit tag FIFO (load/store) of issued requests
module noc_axilite_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_push_tag,
    input  logic                     i_pop,
    output logic                     o_head_tag,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [DEPTH-1:0] r_mem;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_mem    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_push_tag;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Extra pointer MSB separates full from empty when the low bits match.
    assign o_head_tag = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count    = r_wr_ptr - r_rd_ptr;
endmodule

// File: rtl/noc_axilite_resp_sched.sv
// rtl/noc_axilite_resp_sched.sv - orders NoC memory acks into AXI-Lite R/B responses
// Optional NOC_AXILITE_RESP_SCHED_STATS_EN adds saturating retire/error counters.
module noc_axilite_resp_sched
    import noc_axilite_pkg::*;
#(
    parameter int AXI_LITE_DATA_WIDTH = 512,
    parameter int AXI_LITE_RESP_WIDTH = 2,
    parameter int MAX_OUTSTANDING     = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_issue_valid,
    input  logic                               req_issue_is_store,
    output logic                               req_issue_ready,
    input  logic                               noc_valid_in,
    input  logic [`NOC_DATA_WIDTH-1:0]         noc_data_in,
    output logic                               noc_ready_out,
    output logic [AXI_LITE_DATA_WIDTH-1:0]     m_axi_rdata,
    output logic [AXI_LITE_RESP_WIDTH-1:0]     m_axi_rresp,
    output logic                               m_axi_rvalid,
    input  logic                               m_axi_rready,
    output logic [AXI_LITE_RESP_WIDTH-1:0]     m_axi_bresp,
    output logic                               m_axi_bvalid,
    input  logic                               m_axi_bready,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_cnt,
    output logic                               err_pulse
`ifdef NOC_AXILITE_RESP_SCHED_STATS_EN
    ,
    output logic [15:0]                        stat_load_cnt,
    output logic [15:0]                        stat_store_cnt,
    output logic [15:0]                        stat_err_cnt
`endif
);
    localparam int NOC_W = `NOC_DATA_WIDTH;
    localparam int BEATS = AXI_LITE_DATA_WIDTH / NOC_W;

    sched_state_t                   r_state;
    logic [7:0]                     r_len;
    logic [7:0]                     r_idx;
    logic                           r_zero;
    logic [AXI_LITE_DATA_WIDTH-1:0] r_rdata;
    logic [AXI_LITE_RESP_WIDTH-1:0] r_resp;
    logic                           r_rvalid;
    logic                           r_bvalid;
    logic                           r_err;

    logic       w_head;
    logic       w_empty;
    logic       w_full;
    logic       w_issue;
    logic       w_pop;
    logic       w_noc_acc;
    logic [7:0] w_type;
    logic [7:0] w_len;
    logic       w_is_ack;
    logic       w_match;
    logic       w_unused_hdr;

    assign req_issue_ready = !w_full;
    assign w_issue   = req_issue_valid && req_issue_ready;
    assign w_pop     = (r_rvalid && m_axi_rready) || (r_bvalid && m_axi_bready);
    assign noc_ready_out = (r_state != ST_RESP);
    assign w_noc_acc = noc_valid_in && noc_ready_out;
    assign w_type    = noc_data_in[`MSG_TYPE];
    assign w_len     = noc_data_in[`MSG_LENGTH];
    assign w_is_ack  = (w_type == NC_LOAD_MEM_ACK) || (w_type == NC_STORE_MEM_ACK);
    assign w_match   = ((w_type == NC_STORE_MEM_ACK) == (w_head == TAG_STORE));
    assign w_unused_hdr = &{1'b0, noc_data_in};

    noc_axilite_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_issue),
        .i_push_tag (req_issue_is_store),
        .i_pop      (w_pop),
        .o_head_tag (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_count    (outstanding_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_HDR;
            r_len    <= '0;
            r_idx    <= '0;
            r_zero   <= 1'b0;
            r_rdata  <= '0;
            r_resp   <= '0;
            r_rvalid <= 1'b0;
            r_bvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_HDR: if (w_noc_acc) begin
                    r_rdata <= '0;
                    r_len   <= w_len;
                    r_idx   <= '0;
                    if (w_empty || !w_is_ack) begin
                        r_err   <= 1'b1;
                        r_state <= (w_len == 8'd0) ? ST_HDR : ST_DROP;
                    end else begin
                        // Channel always follows the FIFO head; a wrong ack type only downgrades resp.
                        r_resp <= w_match ? AXI_LITE_RESP_WIDTH'(RESP_OKAY)
                                          : AXI_LITE_RESP_WIDTH'(RESP_SLVERR);
                        r_zero <= !w_match;
                        r_err  <= !w_match;
                        if (w_len == 8'd0) begin
                            r_state  <= ST_RESP;
                            r_rvalid <= (w_head == TAG_LOAD);
                            r_bvalid <= (w_head == TAG_STORE);
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: if (w_noc_acc) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (!r_zero && r_idx == 8'(k)) begin
                            r_rdata[k*NOC_W +: NOC_W] <= noc_data_in;
                        end
                    end
                    r_idx <= r_idx + 8'd1;
                    if (r_idx == r_len - 8'd1) begin
                        r_state  <= ST_RESP;
                        r_rvalid <= (w_head == TAG_LOAD);
                        r_bvalid <= (w_head == TAG_STORE);
                    end
                end
                ST_DROP: if (w_noc_acc) begin
                    r_idx <= r_idx + 8'd1;
                    if (r_idx == r_len - 8'd1) begin
                        r_state <= ST_HDR;
                    end
                end
                ST_RESP: if (w_pop) begin
                    r_rvalid <= 1'b0;
                    r_bvalid <= 1'b0;
                    r_state  <= ST_HDR;
                end
                default: r_state <= ST_HDR;
            endcase
        end
    end

    assign m_axi_rdata  = r_rdata;
    assign m_axi_rresp  = r_resp;
    assign m_axi_bresp  = r_resp;
    assign m_axi_rvalid = r_rvalid;
    assign m_axi_bvalid = r_bvalid;
    assign err_pulse    = r_err;

`ifdef NOC_AXILITE_RESP_SCHED_STATS_EN
    logic [15:0] r_stat_load;
    logic [15:0] r_stat_store;
    logic [15:0] r_stat_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_load  <= '0;
            r_stat_store <= '0;
            r_stat_err   <= '0;
        end else begin
            if (r_rvalid && m_axi_rready && r_stat_load != 16'hFFFF) r_stat_load <= r_stat_load + 16'd1;
            if (r_bvalid && m_axi_bready && r_stat_store != 16'hFFFF) r_stat_store <= r_stat_store + 16'd1;
            if (r_err && r_stat_err != 16'hFFFF) r_stat_err <= r_stat_err + 16'd1;
        end
    end

    assign stat_load_cnt  = r_stat_load;
    assign stat_store_cnt = r_stat_store;
    assign stat_err_cnt   = r_stat_err;
`endif
endmodule

// File: tb/tb_noc_axilite_resp_sched.sv
// tb/tb_noc_axilite_resp_sched.sv - directed self-checking bench for noc_axilite_resp_sched
module tb_noc_axilite_resp_sched;
    localparam int NW = 64;
    localparam int AW = 512;
    localparam int RW = 2;
    localparam int MO = 8;
    localparam int CW = 4;
    localparam logic [7:0] T_LD = 8'd26;
    localparam logic [7:0] T_ST = 8'd27;

    logic          clk;
    logic          rst_n;
    logic          req_issue_valid;
    logic          req_issue_is_store;
    logic          req_issue_ready;
    logic          noc_valid_in;
    logic [NW-1:0] noc_data_in;
    logic          noc_ready_out;
    logic [AW-1:0] m_axi_rdata;
    logic [RW-1:0] m_axi_rresp;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [RW-1:0] m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic [CW-1:0] outstanding_cnt;
    logic          err_pulse;
`ifdef NOC_AXILITE_RESP_SCHED_STATS_EN
    logic [15:0]   stat_load_cnt;
    logic [15:0]   stat_store_cnt;
    logic [15:0]   stat_err_cnt;
`endif

    int vec  = 0;
    int miss = 0;

    noc_axilite_resp_sched #(
        .AXI_LITE_DATA_WIDTH (AW),
        .AXI_LITE_RESP_WIDTH (RW),
        .MAX_OUTSTANDING     (MO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_issue_valid    (req_issue_valid),
        .req_issue_is_store (req_issue_is_store),
        .req_issue_ready    (req_issue_ready),
        .noc_valid_in       (noc_valid_in),
        .noc_data_in        (noc_data_in),
        .noc_ready_out      (noc_ready_out),
        .m_axi_rdata        (m_axi_rdata),
        .m_axi_rresp        (m_axi_rresp),
        .m_axi_rvalid       (m_axi_rvalid),
        .m_axi_rready       (m_axi_rready),
        .m_axi_bresp        (m_axi_bresp),
        .m_axi_bvalid       (m_axi_bvalid),
        .m_axi_bready       (m_axi_bready),
        .outstanding_cnt    (outstanding_cnt),
        .err_pulse          (err_pulse)
`ifdef NOC_AXILITE_RESP_SCHED_STATS_EN
        ,
        .stat_load_cnt      (stat_load_cnt),
        .stat_store_cnt     (stat_store_cnt),
        .stat_err_cnt       (stat_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NW-1:0] hdr(input logic [7:0] t, input logic [7:0] l);
        logic [NW-1:0] h;
        h = '0;
        h[29:22] = t;
        h[37:30] = l;
        return h;
    endfunction

    task automatic issue(input logic is_store);
        req_issue_valid = 1'b1;
        req_issue_is_store = is_store;
        tick();
        req_issue_valid = 1'b0;
        req_issue_is_store = 1'b0;
    endtask

    task automatic send_flit(input logic [NW-1:0] d, input string nm);
        int n;
        n = 0;
        noc_valid_in = 1'b1;
        noc_data_in  = d;
        while (!noc_ready_out && n < 20) begin
            tick();
            n++;
        end
        vec++;
        if (noc_ready_out !== 1'b1) begin
            miss++;
            $display("FAIL %s_accept: noc_ready_out=%b after %0d cycles, required 1", nm, noc_ready_out, n);
        end
        tick();
        noc_valid_in = 1'b0;
        noc_data_in  = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_issue_valid = 1'b0;
        req_issue_is_store = 1'b0;
        noc_valid_in = 1'b0;
        noc_data_in = '0;
        m_axi_rready = 1'b0;
        m_axi_bready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        vec++; if ({m_axi_rvalid, m_axi_bvalid, err_pulse} !== 3'b000) begin miss++; $display("FAIL rst_valids: got %b required 000", {m_axi_rvalid, m_axi_bvalid, err_pulse}); end
        vec++; if (m_axi_rdata !== '0) begin miss++; $display("FAIL rst_rdata: got %h required 0", m_axi_rdata); end
        vec++; if ({m_axi_rresp, m_axi_bresp} !== 4'b0000) begin miss++; $display("FAIL rst_resp: got %b required 0000", {m_axi_rresp, m_axi_bresp}); end
        vec++; if (outstanding_cnt !== 4'd0) begin miss++; $display("FAIL rst_cnt: got %0d required 0", outstanding_cnt); end
        vec++; if ({req_issue_ready, noc_ready_out} !== 2'b11) begin miss++; $display("FAIL rst_ready: got %b required 11", {req_issue_ready, noc_ready_out}); end
    endtask

    task automatic test_load_burst;
        logic [AW-1:0] exp_d;
        for (int k = 0; k < 8; k++) exp_d[k*NW +: NW] = 64'(k + 1);
        issue(1'b0);
        vec++; if (outstanding_cnt !== 4'd1) begin miss++; $display("FAIL t1_cnt_issue: got %0d required 1", outstanding_cnt); end
        send_flit(hdr(T_LD, 8'd8), "t1_hdr");
        for (int k = 0; k < 8; k++) send_flit(64'(k + 1), "t1_flit");
        vec++; if ({m_axi_rvalid, m_axi_bvalid} !== 2'b10) begin miss++; $display("FAIL t1_valid: got %b required 10", {m_axi_rvalid, m_axi_bvalid}); end
        vec++; if (m_axi_rdata !== exp_d) begin miss++; $display("FAIL t1_rdata: got %h required %h", m_axi_rdata, exp_d); end
        vec++; if (m_axi_rresp !== 2'b00) begin miss++; $display("FAIL t1_rresp: got %b required 00", m_axi_rresp); end
        m_axi_rready = 1'b1;
        tick();
        m_axi_rready = 1'b0;
        vec++; if ({m_axi_rvalid, outstanding_cnt} !== {1'b0, 4'd0}) begin miss++; $display("FAIL t1_retire: rvalid/cnt got %b/%0d required 0/0", m_axi_rvalid, outstanding_cnt); end
    endtask

    task automatic test_store_backpressure;
        issue(1'b1);
        send_flit(hdr(T_ST, 8'd0), "t2_hdr");
        for (int c = 0; c < 5; c++) begin
            vec++; if ({m_axi_bvalid, m_axi_rvalid, m_axi_bresp, outstanding_cnt} !== {1'b1, 1'b0, 2'b00, 4'd1}) begin
                miss++; $display("FAIL t2_hold: cycle %0d bvalid/rvalid/bresp/cnt got %b/%b/%b/%0d required 1/0/00/1", c, m_axi_bvalid, m_axi_rvalid, m_axi_bresp, outstanding_cnt);
            end
            tick();
        end
        m_axi_bready = 1'b1;
        tick();
        m_axi_bready = 1'b0;
        vec++; if ({m_axi_bvalid, noc_ready_out, outstanding_cnt} !== {1'b0, 1'b1, 4'd0}) begin miss++; $display("FAIL t2_retire: bvalid/noc_ready/cnt got %b/%b/%0d required 0/1/0", m_axi_bvalid, noc_ready_out, outstanding_cnt); end
    endtask

    task automatic test_mixed_order;
        logic [AW-1:0] exp_d;
        issue(1'b0);
        issue(1'b1);
        issue(1'b0);
        vec++; if (outstanding_cnt !== 4'd3) begin miss++; $display("FAIL t3_cnt3: got %0d required 3", outstanding_cnt); end
        m_axi_rready = 1'b1;
        m_axi_bready = 1'b1;
        send_flit(hdr(T_LD, 8'd1), "t3_hdr0");
        send_flit(64'hA, "t3_flit0");
        exp_d = '0; exp_d[NW-1:0] = 64'hA;
        vec++; if ({m_axi_rvalid, m_axi_bvalid} !== 2'b10 || m_axi_rdata !== exp_d) begin miss++; $display("FAIL t3_r0: valids %b rdata %h required 10 %h", {m_axi_rvalid, m_axi_bvalid}, m_axi_rdata, exp_d); end
        send_flit(hdr(T_ST, 8'd0), "t3_hdr1");
        vec++; if ({m_axi_rvalid, m_axi_bvalid, m_axi_bresp, outstanding_cnt} !== {2'b01, 2'b00, 4'd2}) begin miss++; $display("FAIL t3_b1: valids/bresp/cnt %b/%b/%0d required 01/00/2", {m_axi_rvalid, m_axi_bvalid}, m_axi_bresp, outstanding_cnt); end
        send_flit(hdr(T_LD, 8'd1), "t3_hdr2");
        send_flit(64'hB, "t3_flit2");
        exp_d = '0; exp_d[NW-1:0] = 64'hB;
        vec++; if ({m_axi_rvalid, m_axi_bvalid} !== 2'b10 || m_axi_rdata !== exp_d) begin miss++; $display("FAIL t3_r2: valids %b rdata %h required 10 %h", {m_axi_rvalid, m_axi_bvalid}, m_axi_rdata, exp_d); end
        tick();
        m_axi_rready = 1'b0;
        m_axi_bready = 1'b0;
        vec++; if ({m_axi_rvalid, outstanding_cnt} !== {1'b0, 4'd0}) begin miss++; $display("FAIL t3_done: rvalid/cnt %b/%0d required 0/0", m_axi_rvalid, outstanding_cnt); end
    endtask

    task automatic test_outstanding_cap;
        req_issue_valid = 1'b1;
        req_issue_is_store = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        vec++; if ({req_issue_ready, outstanding_cnt} !== {1'b0, 4'd8}) begin miss++; $display("FAIL t4_full: ready/cnt %b/%0d required 0/8", req_issue_ready, outstanding_cnt); end
        tick();
        req_issue_valid = 1'b0;
        vec++; if (outstanding_cnt !== 4'd8) begin miss++; $display("FAIL t4_reject: cnt %0d required 8", outstanding_cnt); end
        send_flit(hdr(T_LD, 8'd0), "t4_hdr_a");
        m_axi_rready = 1'b1;
        tick();
        m_axi_rready = 1'b0;
        vec++; if ({req_issue_ready, outstanding_cnt} !== {1'b1, 4'd7}) begin miss++; $display("FAIL t4_free: ready/cnt %b/%0d required 1/7", req_issue_ready, outstanding_cnt); end
        send_flit(hdr(T_LD, 8'd0), "t4_hdr_b");
        m_axi_rready = 1'b1;
        req_issue_valid = 1'b1;
        tick();
        m_axi_rready = 1'b0;
        req_issue_valid = 1'b0;
        vec++; if ({m_axi_rvalid, req_issue_ready, outstanding_cnt} !== {1'b0, 1'b1, 4'd7}) begin miss++; $display("FAIL t4_same_cycle: rvalid/ready/cnt %b/%b/%0d required 0/1/7", m_axi_rvalid, req_issue_ready, outstanding_cnt); end
        issue(1'b0);
        vec++; if ({req_issue_ready, outstanding_cnt} !== {1'b0, 4'd8}) begin miss++; $display("FAIL t4_refill: ready/cnt %b/%0d required 0/8", req_issue_ready, outstanding_cnt); end
        m_axi_rready = 1'b1;
        for (int k = 0; k < 8; k++) send_flit(hdr(T_LD, 8'd0), "t4_drain");
        vec++; if ({m_axi_rvalid, m_axi_rresp} !== {1'b1, 2'b00}) begin miss++; $display("FAIL t4_last: rvalid/rresp %b/%b required 1/00", m_axi_rvalid, m_axi_rresp); end
        tick();
        m_axi_rready = 1'b0;
        vec++; if ({req_issue_ready, outstanding_cnt} !== {1'b1, 4'd0}) begin miss++; $display("FAIL t4_empty: ready/cnt %b/%0d required 1/0", req_issue_ready, outstanding_cnt); end
    endtask

    task automatic test_mismatch;
        issue(1'b0);
        send_flit(hdr(T_ST, 8'd0), "t5_hdr");
        vec++; if ({m_axi_rvalid, m_axi_bvalid, m_axi_rresp, err_pulse} !== {2'b10, 2'b10, 1'b1}) begin miss++; $display("FAIL t5_resp: valids/rresp/err %b/%b/%b required 10/10/1", {m_axi_rvalid, m_axi_bvalid}, m_axi_rresp, err_pulse); end
        vec++; if (m_axi_rdata !== '0) begin miss++; $display("FAIL t5_rdata: got %h required 0", m_axi_rdata); end
        tick();
        vec++; if ({err_pulse, m_axi_rvalid} !== 2'b01) begin miss++; $display("FAIL t5_pulse: err/rvalid %b required 01", {err_pulse, m_axi_rvalid}); end
        m_axi_rready = 1'b1;
        tick();
        m_axi_rready = 1'b0;
        issue(1'b0);
        send_flit(hdr(T_ST, 8'd1), "t5_hdr_d");
        send_flit(64'hDEAD_BEEF_0000_0001, "t5_flit");
        vec++; if ({m_axi_rvalid, m_axi_rresp} !== {1'b1, 2'b10} || m_axi_rdata !== '0) begin miss++; $display("FAIL t5_forced0: rvalid/rresp %b/%b rdata %h required 1/10 0", m_axi_rvalid, m_axi_rresp, m_axi_rdata); end
        m_axi_rready = 1'b1;
        tick();
        m_axi_rready = 1'b0;
        vec++; if (outstanding_cnt !== 4'd0) begin miss++; $display("FAIL t5_cnt: got %0d required 0", outstanding_cnt); end
    endtask

    task automatic test_unexpected;
        send_flit(hdr(T_LD, 8'd2), "t6_hdr");
        vec++; if ({err_pulse, noc_ready_out, m_axi_rvalid, m_axi_bvalid} !== 4'b1100) begin miss++; $display("FAIL t6_err: err/noc_ready/rvalid/bvalid %b required 1100", {err_pulse, noc_ready_out, m_axi_rvalid, m_axi_bvalid}); end
        send_flit(64'h11, "t6_f0");
        send_flit(64'h22, "t6_f1");
        vec++; if ({err_pulse, m_axi_rvalid, m_axi_bvalid, outstanding_cnt} !== {3'b000, 4'd0}) begin miss++; $display("FAIL t6_after: err/rvalid/bvalid/cnt %b/%0d required 000/0", {err_pulse, m_axi_rvalid, m_axi_bvalid}, outstanding_cnt); end
        issue(1'b0);
        send_flit(hdr(T_LD, 8'd0), "t6_next");
        vec++; if ({m_axi_rvalid, m_axi_rresp, err_pulse} !== {1'b1, 2'b00, 1'b0}) begin miss++; $display("FAIL t6_resync: rvalid/rresp/err %b/%b/%b required 1/00/0", m_axi_rvalid, m_axi_rresp, err_pulse); end
        m_axi_rready = 1'b1;
        tick();
        m_axi_rready = 1'b0;
    endtask

    task automatic test_reset_mid_packet;
        issue(1'b0);
        send_flit(hdr(T_LD, 8'd4), "t7_hdr");
        send_flit(64'h5, "t7_f0");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        vec++; if ({noc_ready_out, m_axi_rvalid, m_axi_bvalid, outstanding_cnt} !== {3'b100, 4'd0} || m_axi_rdata !== '0) begin miss++; $display("FAIL t7_reset: noc_ready/rvalid/bvalid %b cnt %0d rdata %h required 100 0 0", {noc_ready_out, m_axi_rvalid, m_axi_bvalid}, outstanding_cnt, m_axi_rdata); end
    endtask

    initial begin
        test_reset();
        test_load_burst();
        test_store_backpressure();
        test_mixed_order();
        test_outstanding_cap();
        test_mismatch();
        test_unexpected();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
